// File: rtl/ofm_collect_pkg.sv
// Shared constants and row type for the systolic-array output collector.
package ofm_collect_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_OWIDTH = 24;
    localparam int DEF_DEPTH  = 4;

    typedef logic [DEF_WIDTH-1:0][DEF_OWIDTH-1:0] row_t;

    // Width of a counter able to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1) + 1;
    endfunction

endpackage

// File: rtl/ofm_fifo.sv
// Row-wide synchronous FIFO with a registered head-of-queue output.
module ofm_fifo
    import ofm_collect_pkg::*;
#(
    parameter int DW    = DEF_WIDTH * DEF_OWIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic [DW-1:0] rd_data_r;
    logic [DW-1:0] head_nxt_s;
    logic          pop_s;
    logic          push_s;

    // Next-state: pointer/count update and the value the head register shows next cycle.
    always_comb begin
        pop_s        = rd_en && (count_r != (AW+1)'(0));
        push_s       = wr_en && ((count_r != FULL_CNT) || pop_s);
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = rd_data_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + (AW+1)'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - (AW+1)'(1);
        end else begin
            count_nxt_s = count_r;
        end
        // The written row becomes the head only when it lands in an otherwise empty queue.
        if (count_nxt_s == (AW+1)'(0)) begin
            head_nxt_s = rd_data_r;
        end else if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_nxt_s = wr_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Control state and head register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= AW'(0);
            rd_ptr_r  <= AW'(0);
            count_r   <= (AW+1)'(0);
            rd_data_r <= DW'(0);
        end else begin
            wr_ptr_r  <= push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
            rd_ptr_r  <= rd_ptr_nxt_s;
            count_r   <= count_nxt_s;
            rd_data_r <= head_nxt_s;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = rd_data_r;
    assign count   = count_r;
    assign drop    = wr_en && !push_s;

endmodule

// File: rtl/ofm_collect.sv
// Collects skewed column drains from a systolic array, deskews them into
// aligned rows and buffers the rows for a ready/valid consumer.
module ofm_collect
    import ofm_collect_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int OWIDTH = DEF_OWIDTH,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              en_o_i,
    input  logic [WIDTH-1:0][OWIDTH-1:0]  ofm_i,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0][OWIDTH-1:0]  out_row,
    output logic                          drain_rdy,
    input  logic                          clr_err,
    output logic                          ovf,
    output logic                          skew_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = cnt_width(WIDTH);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    logic [WIDTH-1:0]             en_r;
    logic [WIDTH-1:0][OWIDTH-1:0] ofm_r;
    logic [WIDTH-1:0]             aln_vld_s;
    logic [WIDTH-1:0][OWIDTH-1:0] aln_dat_s;
    logic                         complete_s;
    logic                         skew_s;
    logic                         drop_s;
    logic [CW-1:0]                count_s;
    logic [IW-1:0]                inflight_r;
    logic [IW-1:0]                inflight_nxt_s;
    logic                         ovf_r;
    logic                         ovf_nxt_s;
    logic                         skew_r;
    logic                         skew_nxt_s;

    // Input capture; only the valid bits need a reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r <= WIDTH'(0);
        end else begin
            en_r <= en_o_i;
        end
    end

    // Input data capture.
    always_ff @(posedge clk) begin
        ofm_r <= ofm_i;
    end

    // Column w waits WIDTH-1-w cycles so that all columns of a row line up.
    for (genvar w = 0; w < WIDTH; w++) begin : g_col
        localparam int D = WIDTH - 1 - w;
        if (D == 0) begin : g_pass
            assign aln_vld_s[w] = en_r[w];
            assign aln_dat_s[w] = ofm_r[w];
        end else begin : g_dly
            logic [D-1:0]             vld_r;
            logic [D-1:0][OWIDTH-1:0] dat_r;

            // Valid shift chain.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_r <= D'(0);
                end else begin
                    vld_r <= D'({vld_r, en_r[w]});
                end
            end

            // Data shift chain.
            always_ff @(posedge clk) begin
                dat_r <= (D*OWIDTH)'({dat_r, ofm_r[w]});
            end

            assign aln_vld_s[w] = vld_r[D-1];
            assign aln_dat_s[w] = dat_r[D-1];
        end
    end

    assign complete_s = &aln_vld_s;
    assign skew_s     = (|aln_vld_s) && !complete_s;

    ofm_fifo #(
        .DW    (WIDTH * OWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (complete_s),
        .wr_data (aln_dat_s),
        .rd_en   (out_ready),
        .rd_data (out_row),
        .count   (count_s),
        .drop    (drop_s)
    );

    // Row bookkeeping and sticky error next-state; a fresh error beats a clear.
    always_comb begin
        // A row leaves the deskew (written, dropped or discarded) when its column 0 aligns.
        case ({en_r[0], aln_vld_s[0]})
            2'b10:   inflight_nxt_s = inflight_r + IW'(1);
            2'b01:   inflight_nxt_s = (inflight_r != IW'(0)) ? (inflight_r - IW'(1)) : inflight_r;
            default: inflight_nxt_s = inflight_r;
        endcase
        if (drop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_err) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
        if (skew_s) begin
            skew_nxt_s = 1'b1;
        end else if (clr_err) begin
            skew_nxt_s = 1'b0;
        end else begin
            skew_nxt_s = skew_r;
        end
    end

    // In-flight counter and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r <= IW'(0);
            ovf_r      <= 1'b0;
            skew_r     <= 1'b0;
        end else begin
            inflight_r <= inflight_nxt_s;
            ovf_r      <= ovf_nxt_s;
            skew_r     <= skew_nxt_s;
        end
    end

    assign out_valid = (count_s != CW'(0));
    assign drain_rdy = (SW'(count_s) + SW'(inflight_r)) < SW'(DEPTH);
    assign ovf       = ovf_r;
    assign skew_err  = skew_r;

endmodule

// File: tb/tb_ofm_collect.sv
// Scoreboard bench for ofm_collect: skewed row stimulus in, aligned rows out.
module tb_ofm_collect;

    localparam int W  = 8;
    localparam int OW = 16;
    localparam int D  = 4;

    typedef logic [W-1:0][OW-1:0] trow_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     en_o_i;
    trow_t            ofm_i;
    logic             out_valid;
    logic             out_ready;
    trow_t            out_row;
    logic             drain_rdy;
    logic             clr_err;
    logic             ovf;
    logic             skew_err;

    int               checks = 0;
    int               errors = 0;
    trow_t            exp_q[$];
    logic [W-1:0]     fut_en  [W];
    trow_t            fut_dat [W];
    logic             rnd_ready = 1'b0;

    ofm_collect #(.WIDTH(W), .OWIDTH(OW), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .en_o_i    (en_o_i),
        .ofm_i     (ofm_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .drain_rdy (drain_rdy),
        .clr_err   (clr_err),
        .ovf       (ovf),
        .skew_err  (skew_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic apply();
        en_o_i = fut_en[0];
        ofm_i  = fut_dat[0];
    endtask

    task automatic clear_sched();
        for (int k = 0; k < W; k++) begin
            fut_en[k]  = '0;
            fut_dat[k] = '0;
        end
        apply();
    endtask

    // Advance one cycle; the upstream skew schedule moves forward by one slot.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < W - 1; k++) begin
            fut_en[k]  = fut_en[k+1];
            fut_dat[k] = fut_dat[k+1];
        end
        fut_en[W-1]  = '0;
        fut_dat[W-1] = '0;
        apply();
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Schedule a row: column w is presented w cycles after column 0 (now).
    task automatic start_row(input trow_t d, input logic [W-1:0] m);
        for (int w = 0; w < W; w++) begin
            if (m[w]) begin
                fut_en[w][w]  = 1'b1;
                fut_dat[w][w] = d[w];
            end
        end
        apply();
    endtask

    function automatic trow_t rand_row();
        trow_t r;
        for (int w = 0; w < W; w++) r[w] = OW'($urandom);
        return r;
    endfunction

    task automatic wait_empty(input string name);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every accepted row must be the oldest outstanding expected row.
    initial begin
        trow_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_row: got %h want none", out_row);
                end else begin
                    e = exp_q.pop_front();
                    if (out_row !== e) begin
                        errors++;
                        $display("FAIL row_data: got %h want %h", out_row, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        trow_t        d;
        logic [W-1:0] m;
        int           n;
        int           seen;

        rst = 1'b1; out_ready = 1'b0; clr_err = 1'b0;
        clear_sched();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_drain_rdy", drain_rdy, 1'b1);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_skew_err", skew_err, 1'b0);
        chk("rst_out_row", out_row, '0);
        rst = 1'b0;
        repeat (3) tick();

        // Single row, lane value w+1: out_valid exactly W+1 cycles after column 0, for one cycle.
        out_ready = 1'b1;
        for (int w = 0; w < W; w++) d[w] = OW'(w + 1);
        start_row(d, '1);
        exp_q.push_back(d);
        repeat (W) tick();
        chk("lat_early", out_valid, 1'b0);
        tick();
        chk("lat_exact", out_valid, 1'b1);
        tick();
        chk("lat_one_cycle", out_valid, 1'b0);
        wait_empty("single_drain");

        // DEPTH+1 back-to-back rows with no consumer: last row dropped.
        out_ready = 1'b0;
        chk("ovf_pre_drain_rdy", drain_rdy, 1'b1);
        for (int i = 0; i <= D; i++) begin
            d = rand_row();
            start_row(d, '1);
            if (i < D) exp_q.push_back(d);
            tick();
        end
        chk("ovf_drain_rdy_low", drain_rdy, 1'b0);
        repeat (W + 2) tick();
        chk("ovf_set", ovf, 1'b1);
        chk("ovf_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        wait_empty("ovf_drain");
        out_ready = 1'b0;
        chk("ovf_sticky", ovf, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_cleared", ovf, 1'b0);

        // FIFO full, new row completes in the same cycle as a pop: accepted.
        for (int i = 0; i <= D; i++) begin
            d = rand_row();
            start_row(d, '1);
            exp_q.push_back(d);
            if (i < D) tick();
        end
        repeat (W) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fullpop_no_ovf", ovf, 1'b0);
        chk("fullpop_valid", out_valid, 1'b1);
        chk("fullpop_still_full", drain_rdy, 1'b0);
        out_ready = 1'b1;
        wait_empty("fullpop_drain");

        // Row with column 5 missing: no write, skew_err until cleared.
        d = rand_row();
        m = '1;
        m[5] = 1'b0;
        start_row(d, m);
        repeat (W + 2) tick();
        chk("skew_set", skew_err, 1'b1);
        chk("skew_no_write", out_valid, 1'b0);
        chk("skew_drain_rdy", drain_rdy, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("skew_cleared", skew_err, 1'b0);

        // Reset with two rows buffered and two in the deskew.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_row(rand_row(), '1);
            tick();
        end
        repeat (W + 2) tick();
        chk("pre_rst_valid", out_valid, 1'b1);
        for (int i = 0; i < 2; i++) begin
            start_row(rand_row(), '1);
            tick();
        end
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_drain_rdy", drain_rdy, 1'b1);
        chk("midrst_out_row", out_row, '0);
        clear_sched();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        repeat (2 * W) begin
            tick();
            if (out_valid) seen++;
        end
        chk("no_rows_after_rst", 64'(seen), 64'd0);

        // 100 random rows issued only when drain_rdy, random backpressure.
        rnd_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 5000 && n < 100; i++) begin
            if (drain_rdy) begin
                d = rand_row();
                start_row(d, '1);
                exp_q.push_back(d);
                n++;
                tick();
                tick();
            end else begin
                tick();
            end
        end
        chk("rand_issued", 64'(n), 64'd100);
        wait_empty("rand_drain");
        rnd_ready = 1'b0;
        out_ready = 1'b0;
        chk("rand_no_ovf", ovf, 1'b0);
        chk("rand_no_skew", skew_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
